// File: rtl/counter_pkg.sv
// Shared types for the multi-mode counter: overflow modes and the RUN/DONE state.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // SATURATE and ONESHOT clamp at the boundary; WRAP and the reserved code wrap around.
  function automatic logic mode_clamps(input mode_e mode);
    case (mode)
      MODE_SAT:     mode_clamps = 1'b1;
      MODE_ONESHOT: mode_clamps = 1'b1;
      MODE_WRAP:    mode_clamps = 1'b0;
      default:      mode_clamps = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/counter_if.sv
// Parametrised bundle of the counter's signals, with modports for the counter and its driver.
interface counter_if #(
  parameter int WIDTH = 8
) (
  input logic clk
);
  logic             rst_n;
  logic             load_n;
  logic             up_down;
  logic             ce;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] data_load;
  logic             clr_ovf;
  logic [WIDTH-1:0] count_out;
  logic             max_count;
  logic             zero;
  logic             tc;
  logic             ovf_sticky;
  logic             done;

  modport DUT (
    input  clk, rst_n, load_n, up_down, ce, mode, step, limit, data_load, clr_ovf,
    output count_out, max_count, zero, tc, ovf_sticky, done
  );

  modport TEST (
    input  clk, count_out, max_count, zero, tc, ovf_sticky, done,
    output rst_n, load_n, up_down, ce, mode, step, limit, data_load, clr_ovf
  );
endinterface

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event calculation for one enabled count step.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_evt
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic           up_evt_s;
  logic           down_evt_s;
  logic           clamp_s;

  assign sum_s      = {1'b0, count} + {1'b0, step};
  assign diff_s     = {1'b0, count} - {1'b0, step};
  assign up_evt_s   = (sum_s > {1'b0, limit});
  assign down_evt_s = (step > count);
  assign clamp_s    = mode_clamps(mode);

  // Select the stepped value, or the mode's boundary value on an event.
  always_comb begin
    next_count   = count;
    boundary_evt = 1'b0;
    if (step == {WIDTH{1'b0}}) begin
      next_count   = count;
      boundary_evt = 1'b0;
    end else if (up_down) begin
      if (up_evt_s) begin
        boundary_evt = 1'b1;
        next_count   = clamp_s ? limit : {WIDTH{1'b0}};
      end else begin
        boundary_evt = 1'b0;
        next_count   = sum_s[WIDTH-1:0];
      end
    end else begin
      if (down_evt_s) begin
        boundary_evt = 1'b1;
        next_count   = clamp_s ? {WIDTH{1'b0}} : limit;
      end else begin
        boundary_evt = 1'b0;
        next_count   = diff_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/multi_mode_counter.sv
// Loadable up/down counter with programmable limit and step, wrap/saturate/one-shot
// overflow handling, a terminal-count pulse, a sticky overflow flag and a DONE state.
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             up_down,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] data_load,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             tc,
  output logic             ovf_sticky,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);

  mode_e            mode_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] calc_count_s;
  logic [WIDTH-1:0] load_val_s;
  logic             calc_evt_s;
  logic             count_en_s;
  logic             evt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;

  assign mode_s     = mode_e'(mode);
  assign load_val_s = (data_load > limit) ? limit : data_load;
  assign count_en_s = ce && (state_r == ST_RUN);
  assign evt_s      = count_en_s && calc_evt_s;

  counter_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .count        (count_r),
    .step         (step),
    .limit        (limit),
    .up_down      (up_down),
    .mode         (mode_s),
    .next_count   (calc_count_s),
    .boundary_evt (calc_evt_s)
  );

  // Next-state logic: load beats counting; DONE holds until a load.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    ovf_nxt_s   = ovf_r;
    if (!load_n) begin
      state_nxt_s = ST_RUN;
      count_nxt_s = load_val_s;
      tc_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (count_en_s) begin
            count_nxt_s = calc_count_s;
          end else begin
            count_nxt_s = count_r;
          end
          if (evt_s && (mode_s == MODE_ONESHOT)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
          tc_nxt_s = evt_s;
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
          count_nxt_s = count_r;
          tc_nxt_s    = 1'b0;
        end
        default: begin
          state_nxt_s = ST_RUN;
          count_nxt_s = RST_COUNT;
          tc_nxt_s    = 1'b0;
        end
      endcase
    end
    // A simultaneous event outranks the clear request.
    if (evt_s && load_n) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      count_r <= RST_COUNT;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign count_out  = count_r;
  assign tc         = tc_r;
  assign ovf_sticky = ovf_r;
  assign done       = (state_r == ST_DONE);
  assign max_count  = (count_r == limit);
  assign zero       = (count_r == {WIDTH{1'b0}});

endmodule
